// File: rtl/word_serializer_pkg.sv
// Shared state encodings for the serializer and the downstream "0101" detector,
// plus a sizing helper for the serializer's bit counter.
package word_serializer_pkg;

    typedef enum logic [1:0] {
        IDLE       = 2'b00,
        SHIFT      = 2'b01,
        SHIFT_FULL = 2'b10
    } ser_state_e;

    typedef enum logic [1:0] {
        DET_IDLE = 2'b00,
        DET_0    = 2'b01,
        DET_01   = 2'b10,
        DET_010  = 2'b11
    } det_state_e;

    // Never returns zero, so the counter always has at least one bit.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/word_serializer_hold_buf.sv
// One-word holding register with its occupancy flag; the serializer parks a word
// here while the shifter is still busy with the previous one.
module ser_hold_buf
    import word_serializer_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic             load,
    input  logic             unload,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge Clk) begin
        if (rst) begin
            q     <= '0;
            valid <= 1'b0;
        end else if (load) begin
            q     <= d;
            valid <= 1'b1;
        end else if (unload) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/word_serializer.sv
// Parallel-to-serial converter with a one-word skid buffer so that back-to-back
// words leave as a gap-free bit stream, one bit per clock.
module word_serializer
    import word_serializer_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int MSB_FIRST = 1
) (
    input  logic             Clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] In_data,
    input  logic             In_valid,
    output logic             In_ready,
    output logic             Out,
    output logic             Out_valid,
    output logic [1:0]       state
);

    localparam int CW = cnt_width(WIDTH);

    ser_state_e       cur_state;
    ser_state_e       nxt_state;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] hold_q;
    logic [CW-1:0]    cnt;
    logic             hold_valid;
    logic             accept;
    logic             last_bit;
    logic             load_shift_in;
    logic             load_shift_hold;
    logic             load_hold;
    logic             unload_hold;

    assign In_ready = !hold_valid && !rst;
    assign accept   = In_valid && In_ready;
    assign last_bit = (cnt == CW'(WIDTH - 1));

    always_ff @(posedge Clk) begin
        if (rst) begin
            cur_state <= IDLE;
        end else begin
            cur_state <= nxt_state;
        end
    end

    // On the last bit a held word has priority over a fresh one; the hold being
    // full also keeps In_ready low, so both can never compete for the shifter.
    always_comb begin
        nxt_state       = cur_state;
        load_shift_in   = 1'b0;
        load_shift_hold = 1'b0;
        load_hold       = 1'b0;
        unload_hold     = 1'b0;
        case (cur_state)
            IDLE: begin
                if (accept) begin
                    load_shift_in = 1'b1;
                    nxt_state     = SHIFT;
                end
            end
            SHIFT: begin
                if (last_bit) begin
                    if (accept) begin
                        load_shift_in = 1'b1;
                    end else begin
                        nxt_state = IDLE;
                    end
                end else if (accept) begin
                    load_hold = 1'b1;
                    nxt_state = SHIFT_FULL;
                end
            end
            SHIFT_FULL: begin
                if (last_bit) begin
                    load_shift_hold = 1'b1;
                    unload_hold     = 1'b1;
                    nxt_state       = SHIFT;
                end
            end
            default: nxt_state = IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
        end else if (load_shift_in) begin
            shreg <= In_data;
            cnt   <= '0;
        end else if (load_shift_hold) begin
            shreg <= hold_q;
            cnt   <= '0;
        end else if (cur_state == SHIFT || cur_state == SHIFT_FULL) begin
            shreg <= (MSB_FIRST != 0) ? {shreg[WIDTH-2:0], 1'b0} : {1'b0, shreg[WIDTH-1:1]};
            cnt   <= last_bit ? '0 : cnt + 1'b1;
        end
    end

    ser_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .Clk    (Clk),
        .rst    (rst),
        .load   (load_hold),
        .unload (unload_hold),
        .d      (In_data),
        .q      (hold_q),
        .valid  (hold_valid)
    );

    assign Out_valid = (cur_state == SHIFT) || (cur_state == SHIFT_FULL);
    assign Out       = Out_valid & ((MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0]);
    assign state     = cur_state;

endmodule
